// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter (5-9 data bits, parity, 1/2 stop, valid/ready)
module uart_tx_cfg #(
  parameter int DIV_W  = 16,
  parameter int DATA_W = 9
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic [DIV_W-1:0]  i_Clks_Per_Bit,
  input  logic [3:0]        i_Data_Bits,
  input  logic [1:0]        i_Parity,
  input  logic              i_Stop2,
  input  logic              i_TX_Valid,
  input  logic [DATA_W-1:0] i_TX_Data,
  output logic              o_TX_Ready,
  output logic              o_TX_Serial,
  output logic              o_TX_Active,
  output logic              o_TX_Done
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [3:0] N_MAX  = 4'(DATA_W);
  logic [2:0]        state;
  logic [DIV_W-1:0]  cnt, d_r;
  logic [3:0]        bit_idx, n_r, n_in;
  logic [DATA_W-1:0] data_r, mask;
  logic              par_en, par_bit, stop2_r, second, bit_end;
  // clamp the requested frame width and build a mask of the bits actually sent
  always_comb begin
    n_in = i_Data_Bits < 4'd5 ? 4'd5 : (i_Data_Bits > N_MAX ? N_MAX : i_Data_Bits);
    mask = '0;
    for (int i = 0; i < DATA_W; i++) mask[i] = i < int'(n_in);
  end
  assign bit_end    = cnt == d_r - 1'b1;
  assign o_TX_Ready = state == IDLE;
  // frame sequencer: latches config on accept, then walks start/data/parity/stop
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      second      <= 1'b0;
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      o_TX_Done <= 1'b0;
      cnt       <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (i_TX_Valid) begin
          state       <= START;
          data_r      <= i_TX_Data & mask;
          n_r         <= n_in;
          par_en      <= ^i_Parity;
          par_bit     <= (^(i_TX_Data & mask)) ^ (i_Parity == 2'b01);
          stop2_r     <= i_Stop2;
          d_r         <= i_Clks_Per_Bit == '0 ? DIV_W'(1) : i_Clks_Per_Bit;
          bit_idx     <= '0;
          second      <= 1'b0;
          o_TX_Serial <= 1'b0;
          o_TX_Active <= 1'b1;
        end
        START: if (bit_end) begin
          state       <= DATA;
          o_TX_Serial <= data_r[0];
        end
        DATA: if (bit_end) begin
          if (bit_idx == n_r - 1'b1) begin
            state       <= par_en ? PARITY : STOP;
            o_TX_Serial <= par_en ? par_bit : 1'b1;
          end else begin
            bit_idx     <= bit_idx + 1'b1;
            data_r      <= data_r >> 1;
            o_TX_Serial <= data_r[1];
          end
        end
        PARITY: if (bit_end) begin
          state       <= STOP;
          o_TX_Serial <= 1'b1;
        end
        STOP: if (bit_end) begin
          if (stop2_r && !second) second <= 1'b1;
          else begin
            state       <= IDLE;
            o_TX_Active <= 1'b0;
            o_TX_Done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed vector bench for the configurable UART transmitter
module tb_uart_tx_cfg;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpb = '0;
  logic [3:0]  nb = '0;
  logic [1:0]  par = '0;
  logic        stop2 = 1'b0;
  logic        valid = 1'b0;
  logic [8:0]  data = '0;
  logic        ready, serial, active, done;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  nb;
    logic [1:0]  par;
    logic        st2;
    logic [8:0]  data;
    int          dcell;
    int          len;
    logic [12:0] bits;
  } vec_t;

  vec_t vecs[6];

  uart_tx_cfg #(.DIV_W(16), .DATA_W(9)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Clks_Per_Bit(cpb), .i_Data_Bits(nb),
    .i_Parity(par), .i_Stop2(stop2), .i_TX_Valid(valid), .i_TX_Data(data),
    .o_TX_Ready(ready), .o_TX_Serial(serial), .o_TX_Active(active), .o_TX_Done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v, input bit scramble);
    int w = 0;
    @(negedge clk);
    while (!ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_accept", ready, 1);
    cpb = v.d; nb = v.nb; par = v.par; stop2 = v.st2; data = v.data; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    for (int i = 0; i < v.len; i++) begin
      if (i > 0) @(negedge clk);
      if (scramble && i == 3) begin
        cpb = 16'd7; nb = 4'd5; par = 2'b10; stop2 = ~v.st2; data = ~v.data;
      end
      chk("line_bit", serial, v.bits[i / v.dcell]);
      chk("busy_flags", {active, ready, done}, 3'b100);
    end
    @(negedge clk);
    chk("done_cycle", {serial, active, ready, done}, 4'b1011);
    @(negedge clk);
    chk("done_single", done, 0);
  endtask

  initial begin
    vecs[0] = '{16'd4, 4'd8,  2'b00, 1'b0, 9'h0A5, 4, 40, 13'h034A};
    vecs[1] = '{16'd3, 4'd7,  2'b01, 1'b1, 9'h041, 3, 33, 13'h0782};
    vecs[2] = '{16'd0, 4'd12, 2'b10, 1'b0, 9'h155, 1, 12, 13'h0EAA};
    vecs[3] = '{16'd2, 4'd3,  2'b11, 1'b1, 9'h1E3, 2, 16, 13'h00C6};
    vecs[4] = '{16'd1, 4'd6,  2'b01, 1'b0, 9'h1C0, 1, 9,  13'h0180};
    vecs[5] = '{16'd2, 4'd9,  2'b10, 1'b1, 9'h0F3, 2, 26, 13'h19E6};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_hold", {serial, active, ready, done}, 4'b1010);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_release", {serial, active, ready, done}, 4'b1010);
    end
    for (int k = 0; k < 6; k++) run_frame(vecs[k], 1'b0);
    // three back-to-back 0x55 frames with valid held high
    @(negedge clk);
    cpb = 16'd2; nb = 4'd8; par = 2'b00; stop2 = 1'b0; data = 9'h055; valid = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k == 43) valid = 1'b0;
      chk("b2b_ready", ready, (k <= 63) ? (k % 21 == 0) : 1);
      chk("b2b_done", done, (k <= 63) ? (k % 21 == 0) : 0);
      chk("b2b_line", serial, (k <= 63 && (k - 1) % 21 != 20) ? (((k - 1) % 21) / 2) % 2 : 1);
    end
    // reset during the fifth data bit aborts the frame
    @(negedge clk);
    cpb = 16'd4; nb = 4'd8; par = 2'b00; stop2 = 1'b0; data = 9'h0A5; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (21) @(negedge clk);
    chk("abort_d4_bit", serial, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_state", {serial, active, ready, done}, 4'b1010);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_no_done", {serial, done}, 2'b10);
    end
    run_frame(vecs[0], 1'b0);
    // config and data changes mid-frame must not disturb the frame in flight
    run_frame(vecs[1], 1'b1);
    run_frame(vecs[5], 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
